// File: rtl/alu_pkg.sv
// Shared ALU op codes, arbiter FSM state type and op legality helper.
// Pure definitions: no latency, no backpressure.
package alu_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_NOP: op_legal = 1'b1;
            default:                                        op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: move/add/sub/and/not/nop; illegal codes yield zero.
// Latency: zero cycles; no backpressure (pure function of inputs).
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 3
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_MOV:  y = in2;
            OP_ADD:  y = in1 + in2;
            OP_SUB:  y = in1 - in2;
            OP_AND:  y = in1 & in2;
            OP_NOT:  y = ~in1;
            OP_NOP:  y = in1;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; done two cycles after the sampling edge.
// Backpressure: requesters hold req until gnt; one operation at most every 3 cycles.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              err,
    output logic              busy
);

    state_t              state_q, state_d;
    logic                owner_q;
    logic                ptr_q;
    logic                winner;
    logic                legal;
    logic                err_q;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [DATA_W-1:0]   alu_y;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        winner = ptr_q;
        if (req0 && !req1) winner = 1'b0;
        if (req1 && !req0) winner = 1'b1;
    end

    assign legal = op_legal(op_q);

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .op  (op_q),
        .in1 (a_q),
        .in2 (b_q),
        .y   (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        done0   = 1'b0;
        done1   = 1'b0;
        err     = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: if (req0 || req1) state_d = EXEC;
            EXEC: begin
                state_d = DONE;
                gnt0    = !owner_q;
                gnt1    = owner_q;
            end
            DONE: begin
                state_d = IDLE;
                done0   = !owner_q;
                done1   = owner_q;
                err     = err_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            result  <= '0;
            zero    <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req0 || req1) begin
                    owner_q <= winner;
                    op_q    <= winner ? op1 : op0;
                    a_q     <= winner ? a1  : a0;
                    b_q     <= winner ? b1  : b0;
                end
                EXEC: begin
                    result <= legal ? alu_y : '0;
                    zero   <= legal ? (alu_y == '0) : 1'b1;
                    err_q  <= !legal;
                end
                DONE: ptr_q <= !owner_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed stimulus with a result scoreboard popped by an independent done monitor.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic        who;
        logic [15:0] res;
        logic        z;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [2:0]  op0 = '0, op1 = '0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, done0, done1, zero, err, busy;
    logic [15:0] result;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic pg0 = 1'b0, pg1 = 1'b0;

    alu_arbiter #(.DATA_W(16), .OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .zero(zero), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must follow its own gnt and match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (done0 || done1)) begin
            chk("done_after_gnt", {31'd0, done0 ? pg0 : pg1}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none", done0, done1);
            end else begin
                e = exp_q.pop_front();
                chk("done_data", {13'd0, done1, result, zero, err}, {13'd0, e});
            end
        end
        pg0 = gnt0;
        pg1 = gnt1;
    end

    task automatic set_req(input logic who, input logic on, input logic [2:0] o,
                           input logic [15:0] a, input logic [15:0] b);
        if (!who) begin req0 = on; op0 = o; a0 = a; b0 = b; end
        else      begin req1 = on; op1 = o; a1 = a; b1 = b; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_sig(input logic who, input logic want_done, input int limit, output int n);
        bit got = 0;
        n = 0;
        while (!got && n < limit) begin
            @(negedge clk);
            n++;
            if (want_done) got = who ? done1 : done0;
            else           got = who ? gnt1 : gnt0;
        end
        if (!got) n = 99;
    endtask

    task automatic issue_one(input logic who, input logic [2:0] o, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] res, input logic z,
                             input logic e);
        int n;
        @(negedge clk);
        set_req(who, 1'b1, o, a, b);
        exp_q.push_back('{who: who, res: res, z: z, e: e});
        wait_sig(who, 1'b0, 10, n);
        chk("gnt_latency", n, 1);
        // Scramble inputs after grant: only the latched copy may be used.
        set_req(who, 1'b0, 3'b111, 16'hDEAD, 16'hBEEF);
        wait_sig(who, 1'b1, 5, n);
        chk("done_latency", n, 1);
        @(negedge clk);
        chk("hold_idle", {14'd0, result, zero, busy, err}, {14'd0, res, z, 1'b0, 1'b0});
    endtask

    task automatic issue_both(input logic first,
                              input logic [2:0] of, input logic [15:0] af, input logic [15:0] bf,
                              input logic [15:0] rf, input logic zf,
                              input logic [2:0] os, input logic [15:0] as, input logic [15:0] bs,
                              input logic [15:0] rs, input logic zs);
        int n;
        @(negedge clk);
        set_req(first, 1'b1, of, af, bf);
        set_req(!first, 1'b1, os, as, bs);
        exp_q.push_back('{who: first, res: rf, z: zf, e: 1'b0});
        exp_q.push_back('{who: !first, res: rs, z: zs, e: 1'b0});
        wait_sig(first, 1'b0, 10, n);
        chk("first_gnt_latency", n, 1);
        set_req(first, 1'b0, 3'b111, 16'hDEAD, 16'hBEEF);
        wait_sig(!first, 1'b0, 10, n);
        chk("second_gnt_latency", n, 3);
        set_req(!first, 1'b0, 3'b111, 16'hDEAD, 16'hBEEF);
        wait_sig(!first, 1'b1, 5, n);
        chk("second_done_latency", n, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic gseq[$];
        int   dcyc[$];
        int   t;
        int   n;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ctl", {gnt0, gnt1, done0, done1, err, busy}, 0);
        rst_n = 1'b1;

        issue_one(1'b0, OP_ADD, 16'd10, 16'd6, 16'd16, 1'b0, 1'b0);
        issue_one(1'b0, OP_ADD, 16'hFFFF, 16'd2, 16'd1, 1'b0, 1'b0);
        issue_one(1'b1, OP_SUB, 16'd3, 16'd5, 16'hFFFE, 1'b0, 1'b0);

        // Simultaneous requests straight after reset: pointer at 0
        do_reset();
        issue_both(1'b0, OP_SUB, 16'd10, 16'd6, 16'd4, 1'b0,
                         OP_MOV, 16'h1234, 16'd6, 16'd6, 1'b0);

        issue_one(1'b1, OP_SUB, 16'd10, 16'd10, 16'd0, 1'b1, 1'b0);
        issue_one(1'b0, 3'b111, 16'd9, 16'd9, 16'd0, 1'b1, 1'b1);
        // Illegal op by requester 0 still moves the pointer to 1
        issue_both(1'b1, OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 1'b0,
                         OP_AND, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0);
        issue_one(1'b1, 3'b100, 16'd5, 16'd5, 16'd0, 1'b1, 1'b1);
        issue_one(1'b1, OP_NOP, 16'h1234, 16'h5678, 16'h1234, 1'b0, 1'b0);

        // Both requesters held high for four operations
        do_reset();
        set_req(1'b0, 1'b1, OP_ADD, 16'd1, 16'd2);
        set_req(1'b1, 1'b1, OP_AND, 16'hF0F0, 16'h0FF0);
        exp_q.push_back('{who: 1'b0, res: 16'd3,    z: 1'b0, e: 1'b0});
        exp_q.push_back('{who: 1'b1, res: 16'h00F0, z: 1'b0, e: 1'b0});
        exp_q.push_back('{who: 1'b0, res: 16'd3,    z: 1'b0, e: 1'b0});
        exp_q.push_back('{who: 1'b1, res: 16'h00F0, z: 1'b0, e: 1'b0});
        t = 0;
        while (dcyc.size() < 4 && t < 30) begin
            @(negedge clk);
            t++;
            if (gnt0 || gnt1) gseq.push_back(gnt1);
            if (done0 || done1) dcyc.push_back(t);
            if (gseq.size() == 4) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        chk("rr_gnt_count", gseq.size(), 4);
        chk("rr_done_count", dcyc.size(), 4);
        if (gseq.size() == 4) chk("rr_gnt_seq", {28'd0, gseq[0], gseq[1], gseq[2], gseq[3]}, 32'b0101);
        for (int i = 1; i < 4; i++)
            if (i < dcyc.size()) chk("rr_done_gap", dcyc[i] - dcyc[i-1], 3);

        // Reset in the middle of EXEC
        @(negedge clk);
        set_req(1'b0, 1'b1, OP_ADD, 16'd1, 16'd1);
        exp_q.push_back('{who: 1'b0, res: 16'd2, z: 1'b0, e: 1'b0});
        wait_sig(1'b0, 1'b0, 10, n);
        chk("pre_rst_gnt", n, 1);
        rst_n = 1'b0;
        req0 = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_result", result, 0);
        chk("mid_rst_zero", zero, 1);
        chk("mid_rst_ctl", {gnt0, gnt1, done0, done1, err, busy}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", {done0, done1, busy}, 0);
        end
        rst_n = 1'b1;
        issue_one(1'b0, OP_ADD, 16'd7, 16'd8, 16'd15, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand and result width.
REQ-002 SHALL have parameter OP_W, default 3, ALU operation code width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0 and req1, input, 1 each, requester ALU-operation request.
REQ-006 SHALL have ports op0 and op1, input, OP_W each, requester operation code.
REQ-007 SHALL have ports a0, b0, a1 and b1, input, DATA_W each, requester operands in1 and in2.
REQ-008 SHALL have ports gnt0 and gnt1, output, 1 each, requester operands captured; the ALU is executing for that requester.
REQ-009 SHALL have ports done0 and done1, output, 1 each, one-cycle result-valid pulse.
REQ-010 SHALL have port result, output, DATA_W, registered ALU result, shared by both requesters.
REQ-011 SHALL have port zero, output, 1, registered zero flag, high when result == 0.
REQ-012 SHALL have port err, output, 1, high with done when the op code was illegal.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, EXEC and DONE.
REQ-015 SHALL, in IDLE with a request present, select a winner at the clock edge, latch the winner's op/a/b, record owner, and go to EXEC.
REQ-016 SHALL grant the only requester when exactly one req is high, regardless of the priority pointer.
REQ-017 SHALL, when both req are high, grant the requester named by the round-robin pointer.
REQ-018 SHALL assert the owner's gnt for exactly the EXEC cycle.
REQ-019 SHALL, in EXEC, drive the ALU from the latched operands only, so later requester input changes have no effect.
REQ-020 SHALL register the ALU result and zero flag at the end of EXEC and go to DONE.
REQ-021 SHALL assert the owner's done for exactly the DONE cycle, with result, zero and err valid during that cycle.
REQ-022 SHALL, at the end of DONE, set the pointer to the non-owner and return to IDLE.
REQ-023 SHALL hold result and zero at their last values until the next DONE.
REQ-024 SHALL produce done two cycles after the IDLE edge that samples req; throughput is at most one operation per 3 cycles.
REQ-025 SHALL use ALU operation codes 000 move (in2), 001 add, 010 sub, 011 and, 101 not, 110 nop (in1).
REQ-026 SHALL wrap add and sub modulo 2^DATA_W, with no carry output.
REQ-027 SHALL treat op codes 100 and 111 as illegal: result = 0, zero = 1, err = 1 in DONE, and the pointer still advances.
REQ-028 SHALL require a requester to hold req, op and operands stable until its gnt, and to drop req in the cycle after done.
REQ-029 SHALL treat any req still high in the cycle after done as a new request.
REQ-030 SHALL leave a req that is raised while busy pending until IDLE, and SHALL never drop it.

Reset
REQ-031 SHALL, on rst_n low, immediately force state to IDLE, the pointer to 0, and gnt0/1, done0/1, err and busy to 0.
REQ-032 SHALL, on rst_n low, set result to 0 and zero to 1.
REQ-033 SHALL, on reset during EXEC or DONE, abandon the operation with no done pulse, and the requester SHALL re-request.
REQ-034 SHALL act on its first request at the first rising clk edge after rst_n deasserts.

Structure
REQ-035 SHALL take the op code constants (OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_NOP) and the FSM state typedef from the shared package alu_pkg.
REQ-036 SHALL instantiate the existing combinational alu exactly once as its sub-module; the illegal-op masking is done in alu_arbiter.

Verification
REQ-037 SHALL cover: req0, op 001, a0 = 10, b0 = 6 -> gnt0 next cycle, done0 the cycle after, result = 16, zero = 0.
REQ-038 SHALL cover: req0 and req1 together after reset, op0 = 010 (10, 6), op1 = 000 (x, 6) -> requester 0 served first with result 4, then requester 1 with result 6.
REQ-039 SHALL cover: req1, op 010, a1 = 10, b1 = 10 -> result = 0, zero = 1, err = 0.
REQ-040 SHALL cover: req0, op 111 -> done0, err = 1, result = 0, zero = 1, the pointer flips to 1.
REQ-041 SHALL cover: both requesters held high continuously for 4 operations -> grants alternate 0, 1, 0, 1, with done every 3rd cycle.
REQ-042 SHALL cover: rst_n pulsed low during EXEC -> no done, busy = 0, result = 0, zero = 1, and a subsequent request completes normally.
